game_tick_scheduler: RTL and testbench

- Run/pause/over sequencer for game timing.
- Drives `start` and `sync_reset` of the 1-second time-tick divider.
- Counts elapsed game seconds from the divider's `time_tik` output.
- Generates the snake-move pulse, whose period shortens as the score rises.
- Sits between the game-control FSM (start/pause/game-over) and the snake datapath/score display.

---
 rtl/game_timing_pkg.sv | 30 +++
 rtl/move_interval_counter.sv | 32 +++
 rtl/game_tick_scheduler.sv | 136 +++++++++++++
 tb/tb_game_tick_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_timing_pkg.sv
// Shared timing constants, state encoding and speed-level helper for the
// game tick scheduler and its move-interval counter.
package game_timing_pkg;

    localparam int CLK_FREQ_HZ     = 25_000_000;
    localparam int BASE_PERIOD_DEF = CLK_FREQ_HZ / 2;
    localparam int STEP_PERIOD_DEF = BASE_PERIOD_DEF / 10;
    localparam int MAX_LEVEL_DEF   = 7;
    localparam int LEVEL_SHIFT_DEF = 2;
    localparam int MOVE_BITS_DEF   = 24;
    localparam int SEC_MAX_DEF     = 999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    // Speed level derived from the score, saturated at max_level.
    function automatic logic [2:0] level_of(input logic [7:0] score,
                                            input int shift,
                                            input int max_level);
        logic [7:0] lvl;
        lvl = score >> shift;
        if (int'(lvl) > max_level) return 3'(max_level);
        return lvl[2:0];
    endfunction

endpackage

// File: rtl/move_interval_counter.sv
// Free-running interval counter with loadable terminal value; holds when
// disabled and flags the terminal cycle, wrapping to zero on it.
module move_interval_counter #(
    parameter int MOVE_BITS = 24
) (
    input  logic                 clock_25,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [MOVE_BITS-1:0] period_m1,
    output logic                 terminal
);

    logic [MOVE_BITS-1:0] count_q, count_d;

    // >= rather than == so a shortened period can never be overrun.
    assign terminal = enable && (count_q >= period_m1);

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable)
            count_d = terminal ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Run/pause/over sequencer: drives the 1 s divider, counts elapsed seconds
// and issues the score-dependent snake move pulse.
module game_tick_scheduler
    import game_timing_pkg::*;
#(
    parameter int BASE_PERIOD = BASE_PERIOD_DEF,
    parameter int STEP_PERIOD = STEP_PERIOD_DEF,
    parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
    parameter int LEVEL_SHIFT = LEVEL_SHIFT_DEF,
    parameter int MOVE_BITS   = MOVE_BITS_DEF,
    parameter int SEC_MAX     = SEC_MAX_DEF
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       start_game,
    input  logic       pause_toggle,
    input  logic       game_over,
    input  logic [7:0] score,
    input  logic       time_tik,
    output logic       div_start,
    output logic       div_sync_reset,
    output logic       move_tick,
    output logic [9:0] elapsed_sec,
    output logic [2:0] speed_level,
    output logic       running
);

    generate
        if (BASE_PERIOD <= MAX_LEVEL * STEP_PERIOD || MAX_LEVEL > 7 ||
            BASE_PERIOD - 1 >= 2 ** MOVE_BITS) begin : g_bad_params
            $error("game_tick_scheduler: invalid period/level parameters");
        end
    endgenerate

    game_state_e          state_q, state_d;
    logic [2:0]           level_q, level_d;
    logic [9:0]           sec_q, sec_d;
    logic                 tik_prev_q, tik_prev_d;
    logic                 move_tick_q, move_tick_d;
    logic                 running_q, running_d;
    logic                 div_start_q, div_start_d;
    logic                 div_sync_reset_q, div_sync_reset_d;
    logic                 cnt_clear;
    logic                 run_adv;
    logic                 terminal;
    logic                 tik_rise;
    logic [MOVE_BITS-1:0] period_m1;

    // Advancing only when no higher-priority event claims this cycle.
    assign run_adv   = (state_q == ST_RUN) && !game_over && !pause_toggle;
    assign tik_rise  = time_tik & ~tik_prev_q;
    assign period_m1 = MOVE_BITS'(BASE_PERIOD - int'(level_q) * STEP_PERIOD - 1);

    move_interval_counter #(.MOVE_BITS(MOVE_BITS)) u_move_cnt (
        .clock_25  (clock_25),
        .reset     (reset),
        .clear     (cnt_clear),
        .enable    (run_adv),
        .period_m1 (period_m1),
        .terminal  (terminal)
    );

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        sec_d       = sec_q;
        tik_prev_d  = 1'b0;
        move_tick_d = 1'b0;
        cnt_clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_game) begin
                    state_d   = ST_RUN;
                    cnt_clear = 1'b1;
                    sec_d     = '0;
                    level_d   = level_of(score, LEVEL_SHIFT, MAX_LEVEL);
                end
            end
            ST_RUN: begin
                tik_prev_d = time_tik;
                if (game_over)
                    state_d = ST_OVER;
                else if (pause_toggle)
                    state_d = ST_PAUSE;
                else begin
                    if (terminal) begin
                        move_tick_d = 1'b1;
                        level_d     = level_of(score, LEVEL_SHIFT, MAX_LEVEL);
                    end
                    if (tik_rise && sec_q < 10'(SEC_MAX))
                        sec_d = sec_q + 10'd1;
                end
            end
            ST_PAUSE: begin
                if (game_over)
                    state_d = ST_OVER;
                else if (pause_toggle)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
        running_d        = (state_d == ST_RUN);
        div_start_d      = (state_d == ST_RUN);
        div_sync_reset_d = (state_d == ST_IDLE) || (state_d == ST_OVER);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            level_q          <= '0;
            sec_q            <= '0;
            tik_prev_q       <= 1'b0;
            move_tick_q      <= 1'b0;
            running_q        <= 1'b0;
            div_start_q      <= 1'b0;
            div_sync_reset_q <= 1'b1;
        end else begin
            state_q          <= state_d;
            level_q          <= level_d;
            sec_q            <= sec_d;
            tik_prev_q       <= tik_prev_d;
            move_tick_q      <= move_tick_d;
            running_q        <= running_d;
            div_start_q      <= div_start_d;
            div_sync_reset_q <= div_sync_reset_d;
        end
    end

    assign div_start      = div_start_q;
    assign div_sync_reset = div_sync_reset_q;
    assign move_tick      = move_tick_q;
    assign elapsed_sec    = sec_q;
    assign speed_level    = level_q;
    assign running        = running_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with short move periods.
module tb_game_tick_scheduler;

    logic       clock_25;
    logic       reset;
    logic       start_game;
    logic       pause_toggle;
    logic       game_over;
    logic [7:0] score;
    logic       time_tik;
    logic       div_start;
    logic       div_sync_reset;
    logic       move_tick;
    logic [9:0] elapsed_sec;
    logic [2:0] speed_level;
    logic       running;

    int checks = 0;
    int errors = 0;

    game_tick_scheduler #(
        .BASE_PERIOD (20),
        .STEP_PERIOD (2),
        .MAX_LEVEL   (7),
        .LEVEL_SHIFT (2)
    ) dut (
        .clock_25       (clock_25),
        .reset          (reset),
        .start_game     (start_game),
        .pause_toggle   (pause_toggle),
        .game_over      (game_over),
        .score          (score),
        .time_tik       (time_tik),
        .div_start      (div_start),
        .div_sync_reset (div_sync_reset),
        .move_tick      (move_tick),
        .elapsed_sec    (elapsed_sec),
        .speed_level    (speed_level),
        .running        (running)
    );

    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] score;
        int         exp_interval;
        int         exp_level;
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clock_25);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!move_tick && n < limit);
        if (!move_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual none required move_tick within %0d", limit);
        end
    endtask

    task automatic tik_pulse();
        time_tik = 1'b1;
        step();
        time_tik = 1'b0;
        step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_move_tick"}, int'(move_tick), 0);
        chk({tag, "_running"}, int'(running), 0);
        chk({tag, "_div_start"}, int'(div_start), 0);
        chk({tag, "_div_sync_reset"}, int'(div_sync_reset), 1);
        chk({tag, "_elapsed"}, int'(elapsed_sec), 0);
        chk({tag, "_level"}, int'(speed_level), 0);
    endtask

    initial begin
        int n;
        logic saw_tick;

        // score applied mid-interval; interval measured tick-to-tick
        tbl[0] = '{8'd12,  20, 3};
        tbl[1] = '{8'd255, 14, 7};
        tbl[2] = '{8'd4,    6, 1};
        tbl[3] = '{8'd31,  18, 7};
        tbl[4] = '{8'd28,   6, 7};
        tbl[5] = '{8'd0,    6, 0};
        tbl[6] = '{8'd3,   20, 0};

        reset = 1'b1; start_game = 1'b0; pause_toggle = 1'b0;
        game_over = 1'b0; score = 8'd0; time_tik = 1'b0;
        #3 reset = 1'b0;
        #2 chk_reset_vals("por");
        step(); step();
        chk_reset_vals("rst_hold");
        reset = 1'b1;
        step();
        chk("idle_sync_reset", int'(div_sync_reset), 1);

        // 1: start at level 0
        start_game = 1'b1; step(); start_game = 1'b0;
        chk("start_sync_reset", int'(div_sync_reset), 0);
        chk("start_div_start", int'(div_start), 1);
        chk("start_running", int'(running), 1);
        wait_tick(60, n);
        chk("first_interval", n, 20);
        step();
        chk("tick_one_cycle", int'(move_tick), 0);
        wait_tick(60, n);
        chk("second_interval", n + 1, 20);
        wait_tick(60, n);
        chk("third_interval", n, 20);
        chk("level0", int'(speed_level), 0);

        // 2: level changes only on move boundaries
        foreach (tbl[i]) begin
            n = 0;
            do begin
                step();
                n++;
                if (n == 3) score = tbl[i].score;
            end while (!move_tick && n < 60);
            chk($sformatf("interval[%0d]", i), n, tbl[i].exp_interval);
            chk($sformatf("level[%0d]", i), int'(speed_level), tbl[i].exp_level);
        end

        // 3: seconds, pause and resume from held count
        repeat (5) tik_pulse();
        chk("elapsed5", int'(elapsed_sec), 5);
        wait_tick(60, n);
        repeat (5) step();
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        chk("pause_div_start", int'(div_start), 0);
        chk("pause_running", int'(running), 0);
        saw_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            time_tik = 1'b1; step(); saw_tick |= move_tick;
            time_tik = 1'b0; step(); saw_tick |= move_tick;
        end
        repeat (10) begin step(); saw_tick |= move_tick; end
        chk("pause_no_tick", int'(saw_tick), 0);
        chk("pause_elapsed", int'(elapsed_sec), 5);
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        chk("resume_running", int'(running), 1);
        chk("resume_div_start", int'(div_start), 1);
        wait_tick(60, n);
        chk("resume_remaining", n, 15);

        // 5: game_over + pause_toggle + tik edge on the move terminal count
        repeat (19) step();
        game_over = 1'b1; pause_toggle = 1'b1; time_tik = 1'b1;
        step();
        pause_toggle = 1'b0; time_tik = 1'b0;
        chk("over_no_tick", int'(move_tick), 0);
        chk("over_running", int'(running), 0);
        chk("over_sync_reset", int'(div_sync_reset), 1);
        chk("over_div_start", int'(div_start), 0);
        chk("over_elapsed", int'(elapsed_sec), 5);
        saw_tick = 1'b0;
        repeat (30) begin step(); saw_tick |= move_tick; end
        chk("over_frozen_tick", int'(saw_tick), 0);
        chk("over_frozen_level", int'(speed_level), 0);
        game_over = 1'b0; score = 8'd20;
        start_game = 1'b1; step(); start_game = 1'b0;
        chk("restart_elapsed", int'(elapsed_sec), 0);
        chk("restart_running", int'(running), 1);
        chk("restart_level", int'(speed_level), 5);
        wait_tick(60, n);
        chk("restart_interval", n, 10);

        // 4: seconds saturate at 999
        repeat (998) tik_pulse();
        chk("elapsed998", int'(elapsed_sec), 998);
        tik_pulse();
        chk("elapsed999", int'(elapsed_sec), 999);
        repeat (5) tik_pulse();
        chk("elapsed_sat", int'(elapsed_sec), 999);

        // 6: async reset while paused
        pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
        chk("pre_rst_pause", int'(running), 0);
        #5 reset = 1'b0;
        #1 chk_reset_vals("async");
        start_game = 1'b1; step(); start_game = 1'b0;
        reset = 1'b1;
        step(); step();
        chk("rst_start_ignored", int'(running), 0);
        chk("rst_idle_sync", int'(div_sync_reset), 1);
        start_game = 1'b1; step(); start_game = 1'b0;
        chk("post_rst_start", int'(running), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
